// File: rtl/spi_controller_xfer.sv
// -----------------------------------------------------------------------------
// spi_controller_xfer
//   SPI initiator for the register-target protocol. One start pulse runs one
//   frame of 8 + REG_WIDTH bits: command byte {rw, zero pad, addr} followed by
//   one data byte, MSB first. All four CPOL/CPHA modes are supported and the
//   SCLK half-period is clk_div+1 system clocks.
//
//   Ports
//     clk, rst_n         system clock, asynchronous active-low reset
//     ena                clock enable; low freezes every register
//     start              one-cycle request, honoured only when idle
//     rw, addr, wdata    frame contents (rw=1 write, rw=0 read)
//     cpol, cpha         SPI mode
//     clk_div            SCLK half-period minus one, in clk cycles
//     busy, done         frame in progress / one-cycle completion pulse
//     rdata              data byte of the most recent read
//     spi_cs_n, spi_clk, spi_mosi, spi_miso   SPI pins
// -----------------------------------------------------------------------------
module spi_controller_xfer #(
    parameter int ADDR_WIDTH = 3,
    parameter int REG_WIDTH  = 8,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  start,
    input  logic                  rw,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [REG_WIDTH-1:0]  wdata,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [DIV_WIDTH-1:0]  clk_div,
    output logic                  busy,
    output logic                  done,
    output logic [REG_WIDTH-1:0]  rdata,
    output logic                  spi_cs_n,
    output logic                  spi_clk,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

    localparam int FRAME_W = 8 + REG_WIDTH;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_GAP} state_t;

    state_t                 state_q, state_d;
    logic [DIV_WIDTH-1:0]   hcnt_q, hcnt_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]     tx_q, tx_d;
    logic [REG_WIDTH-1:0]   rx_q, rx_d;
    logic [REG_WIDTH-1:0]   rdata_q, rdata_d;
    logic                   rw_q, rw_d;
    logic                   cpol_q, cpol_d;
    logic                   cpha_q, cpha_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   cs_n_q, cs_n_d;
    logic                   sclk_q, sclk_d;
    logic                   mosi_q, mosi_d;

    logic [7:0]             cmd_byte;
    logic                   hcnt_end;
    logic                   lead_edge;

    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rdata_d   = rdata_q;
        rw_d      = rw_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;

        cmd_byte                   = '0;
        cmd_byte[7]                = rw;
        cmd_byte[ADDR_WIDTH-1:0]   = addr;

        hcnt_end  = (hcnt_q == '0);
        // SCLK sitting at its idle level means the next toggle is a leading edge.
        lead_edge = (sclk_q == cpol_q);

        case (state_q)
            S_IDLE: begin
                // Idle SCLK tracks the live cpol so the pin is correct before cs_n falls.
                sclk_d = cpol;
                mosi_d = 1'b0;
                cs_n_d = 1'b1;
                busy_d = 1'b0;
                if (start) begin
                    rw_d      = rw;
                    cpol_d    = cpol;
                    cpha_d    = cpha;
                    div_d     = clk_div;
                    hcnt_d    = clk_div;
                    tx_d      = {cmd_byte, wdata};
                    bit_cnt_d = '0;
                    busy_d    = 1'b1;
                    cs_n_d    = 1'b0;
                    mosi_d    = rw;
                    state_d   = S_SETUP;
                end
            end

            S_SETUP: begin
                if (hcnt_end) begin
                    hcnt_d  = div_q;
                    state_d = S_XFER;
                end else begin
                    hcnt_d = hcnt_q - DIV_WIDTH'(1);
                end
            end

            S_XFER: begin
                if (hcnt_end) begin
                    hcnt_d = div_q;
                    sclk_d = ~sclk_q;
                    if (lead_edge) begin
                        if (!cpha_q) begin
                            rx_d = {rx_q[REG_WIDTH-2:0], spi_miso};
                        end else if (bit_cnt_q != '0) begin
                            // CPHA=1 presents the MSB on the first leading edge, so no shift there.
                            tx_d = {tx_q[FRAME_W-2:0], 1'b0};
                        end
                    end else begin
                        if (cpha_q) begin
                            rx_d = {rx_q[REG_WIDTH-2:0], spi_miso};
                        end else begin
                            tx_d = {tx_q[FRAME_W-2:0], 1'b0};
                        end
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = S_HOLD;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end
                    mosi_d = tx_d[FRAME_W-1];
                end else begin
                    hcnt_d = hcnt_q - DIV_WIDTH'(1);
                end
            end

            S_HOLD: begin
                sclk_d = cpol_q;
                if (hcnt_end) begin
                    hcnt_d  = div_q;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = S_GAP;
                end else begin
                    hcnt_d = hcnt_q - DIV_WIDTH'(1);
                end
            end

            S_GAP: begin
                if (hcnt_end) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sclk_d  = cpol;
                    if (!rw_q) begin
                        rdata_d = rx_q;
                    end
                end else begin
                    hcnt_d = hcnt_q - DIV_WIDTH'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            hcnt_q    <= '0;
            div_q     <= '0;
            bit_cnt_q <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rdata_q   <= '0;
            rw_q      <= 1'b0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else if (ena) begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rdata_q   <= rdata_d;
            rw_q      <= rw_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign spi_cs_n = cs_n_q;
    assign spi_clk  = sclk_q;
    assign spi_mosi = mosi_q;

endmodule
